// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU port (C) and the
// debug/loader port (D). At most one transfer is granted per cycle. Ties are
// broken round-robin, and a lock flag lets one port keep ownership across a
// multi-word sequence. Read data is routed back to the issuing port in issue order.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   c_req/c_we/c_lock         CPU request, write flag, hold-ownership flag
//   c_addr/c_wdata/c_be       CPU byte address, write data, byte enables
//   c_gnt                     CPU transfer accepted this cycle (combinational)
//   c_rvalid/c_rdata          CPU read return
//   d_*                       the same set for the debug port
//   m_en/m_we/m_addr/...      memory-side strobe, write flag, address, data, enables
//   m_rdata                   memory read data, MEM_LATENCY cycles after a read m_en
module dmem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                c_req,
    input  logic                c_we,
    input  logic                c_lock,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic                d_lock,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam logic PortC = 1'b0;
    localparam logic PortD = 1'b1;

    typedef enum logic [1:0] {StIdle, StLockC, StLockD} state_e;

    state_e                 state_q;
    logic                   rr_last_q;
    logic [MEM_LATENCY-1:0] tag_valid_q;
    logic [MEM_LATENCY-1:0] tag_port_q;
    logic [DATA_W-1:0]      c_rdata_q;
    logic [DATA_W-1:0]      d_rdata_q;

    logic grant_c;
    logic grant_d;
    logic issue_read;
    logic tail_valid;
    logic tail_port;

    // Grant decision. Gated by reset_n so nothing is granted while reset is held.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                StIdle: begin
                    if (c_req && d_req) begin
                        grant_c = (rr_last_q == PortD);
                        grant_d = (rr_last_q == PortC);
                    end else begin
                        grant_c = c_req;
                        grant_d = d_req;
                    end
                end
                StLockC: grant_c = c_req;
                StLockD: grant_d = d_req;
                default: ;
            endcase
        end
    end

    assign c_gnt = grant_c;
    assign d_gnt = grant_d;

    // Memory side is a pure mux of the winner's fields.
    always_comb begin
        m_en    = grant_c | grant_d;
        m_we    = 1'b0;
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_be    = '0;
        if (grant_c) begin
            m_we = c_we;
            m_be = c_be;
        end else if (grant_d) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end
    end

    // Ownership state and round-robin history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_last_q <= PortD;
        end else if (grant_c) begin
            rr_last_q <= PortC;
            state_q   <= c_lock ? StLockC : StIdle;
        end else if (grant_d) begin
            rr_last_q <= PortD;
            state_q   <= d_lock ? StLockD : StIdle;
        end
    end

    // Owner tags travel alongside the memory pipeline; a tag reaches the tail in
    // the same cycle its read data appears on m_rdata.
    assign issue_read = m_en && !m_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_q <= '0;
            tag_port_q  <= '0;
        end else begin
            tag_valid_q[0] <= issue_read;
            tag_port_q[0]  <= grant_d;
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_port_q[i]  <= tag_port_q[i-1];
            end
        end
    end

    assign tail_valid = tag_valid_q[MEM_LATENCY-1];
    assign tail_port  = tag_port_q[MEM_LATENCY-1];

    assign c_rvalid = tail_valid && (tail_port == PortC);
    assign d_rvalid = tail_valid && (tail_port == PortD);

    // The returned word is presented during its rvalid cycle and captured so the
    // port keeps showing it until its next return.
    assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
    assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (c_rvalid) begin
                c_rdata_q <= m_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= m_rdata;
            end
        end
    end

endmodule
